// File: rtl/key_debouncer_if.sv
// Pushbutton-to-HMI signal bundle for key_debouncer: raw keys in, command pulses and debounced levels out.
interface key_debouncer_if;
  logic [3:0] KEY;
  logic       btn_increase;
  logic       btn_decrease;
  logic       btn_start;
  logic       btn_stop;
  logic [3:0] key_state;

  modport master (
    output KEY,
    input  btn_increase, btn_decrease, btn_start, btn_stop, key_state
  );

  modport slave (
    input  KEY,
    output btn_increase, btn_decrease, btn_start, btn_stop, key_state
  );
endinterface

// File: rtl/key_debouncer.sv
// Synchronises and debounces four active-low keys and emits arbitrated one-cycle command pulses,
// with auto-repeat on increase/decrease.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input logic           clk,
  input logic           rst,
  key_debouncer_if.slave bus
);

  localparam int unsigned DW      = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = ($clog2(REP_MAX) > 0) ? $clog2(REP_MAX) : 1;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [3:0]    sync1, sync2;   // active-high: 1 = pressed
  logic [3:0]    stable;
  logic [3:0]    armed;
  logic [1:0]    flush;
  logic [DW-1:0] db_cnt [4];

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_act;
  logic [1:0]    rep_first;

  logic [3:0] differ, toggle, press_evt, evt;
  logic [1:0] rep_hit;
  logic       nxt_inc, nxt_dec, nxt_start, nxt_stop;
  logic       inc_q, dec_q, start_q, stop_q;

  always_comb begin
    differ    = '0;
    toggle    = '0;
    press_evt = '0;
    rep_hit   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      differ[i]    = sync2[i] ^ stable[i];
      toggle[i]    = differ[i] && (db_cnt[i] == DB_LAST);
      press_evt[i] = toggle[i] && !stable[i] && armed[i];
    end
    // A repeat that would coincide with the release transition is dropped.
    for (int unsigned i = 0; i < 2; i++) begin
      rep_hit[i] = REPEAT_EN && rep_act[i] && stable[i] && !toggle[i] &&
                   (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : PERIOD_LAST));
    end
    evt       = press_evt | {2'b00, rep_hit};
    nxt_inc   = evt[0] && !evt[1];
    nxt_dec   = evt[1] && !evt[0];
    nxt_start = evt[2] && !evt[3];
    nxt_stop  = evt[3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      armed   <= '0;
      flush   <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
      for (int unsigned i = 0; i < 2; i++) rep_cnt[i] <= '0;
      rep_act   <= '0;
      rep_first <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      sync1  <= ~bus.KEY;
      sync2  <= sync1;
      stable <= stable ^ toggle;
      // Arm only once sync2 carries a real post-reset sample, so a key held through reset stays unarmed.
      flush  <= {flush[0], 1'b1};
      armed  <= armed | ({4{flush[1]}} & ~sync2);

      for (int unsigned i = 0; i < 4; i++) begin
        if (!differ[i] || toggle[i]) db_cnt[i] <= '0;
        else                         db_cnt[i] <= db_cnt[i] + 1'b1;
      end

      for (int unsigned i = 0; i < 2; i++) begin
        if (press_evt[i]) begin
          rep_cnt[i]   <= '0;
          rep_act[i]   <= 1'b1;
          rep_first[i] <= 1'b1;
        end else if (!stable[i] || toggle[i]) begin
          rep_cnt[i]   <= '0;
          rep_act[i]   <= 1'b0;
          rep_first[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b0;
        end else if (rep_act[i]) begin
          rep_cnt[i]   <= rep_cnt[i] + 1'b1;
        end
      end

      inc_q   <= nxt_inc;
      dec_q   <= nxt_dec;
      start_q <= nxt_start;
      stop_q  <= nxt_stop;
    end
  end

  assign bus.btn_increase = inc_q;
  assign bus.btn_decrease = dec_q;
  assign bus.btn_start    = start_q;
  assign bus.btn_stop     = stop_q;
  assign bus.key_state    = stable;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: segment table plus hand-timed sequences for latency, repeat and reset.
module tb_key_debouncer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_debouncer_if bus0 ();
  key_debouncer_if bus1 ();
  assign bus1.KEY = bus0.KEY;

  key_debouncer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b1)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  key_debouncer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [3:0]  key;
    int unsigned cycles;
    int          n_inc;
    int          n_dec;
    int          n_start;
    int          n_stop;
    logic [3:0]  state;
  } seg_t;

  seg_t segs[$];

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int base = 0;
  int n_inc, n_dec, n_start, n_stop;
  int dec_edges[$];
  int dec1_edges[$];

  always @(posedge clk) edge_no++;

  always @(negedge clk) begin
    if (bus0.btn_increase) n_inc++;
    if (bus0.btn_decrease) begin n_dec++; dec_edges.push_back(edge_no); end
    if (bus0.btn_start)    n_start++;
    if (bus0.btn_stop)     n_stop++;
    if (bus1.btn_decrease) dec1_edges.push_back(edge_no);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_inc = 0; n_dec = 0; n_start = 0; n_stop = 0;
    dec_edges.delete();
    dec1_edges.delete();
  endtask

  task automatic wait_edge(input int k);
    while (edge_no < base + k) @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " inc"},   int'(bus0.btn_increase), 0);
    chk({name, " dec"},   int'(bus0.btn_decrease), 0);
    chk({name, " start"}, int'(bus0.btn_start), 0);
    chk({name, " stop"},  int'(bus0.btn_stop), 0);
    chk({name, " state"}, int'(bus0.key_state), 0);
  endtask

  initial begin
    int exp_rep[6];
    exp_rep = '{6, 16, 19, 22, 25, 28};

    // bounce: 3-cycle low/high runs never reach the 4-cycle threshold
    for (int i = 0; i < 10; i++)
      segs.push_back('{(i % 2 == 0) ? 4'b1110 : 4'b1111, 3, 0, 0, 0, 0, 4'b0000});
    segs.push_back('{4'b1111, 10, 0, 0, 0, 0, 4'b0000});
    // start+stop together: stop wins
    segs.push_back('{4'b0011, 12, 0, 0, 0, 1, 4'b1100});
    segs.push_back('{4'b1111, 12, 0, 0, 0, 0, 4'b0000});
    // increase+decrease together: both dropped
    segs.push_back('{4'b1100,  8, 0, 0, 0, 0, 4'b0011});
    segs.push_back('{4'b1111, 12, 0, 0, 0, 0, 4'b0000});
    // start+increase: independent, both pulse
    segs.push_back('{4'b1010,  8, 1, 0, 1, 0, 4'b0101});
    segs.push_back('{4'b1111, 12, 0, 0, 0, 0, 4'b0000});

    rst = 1'b0;
    bus0.KEY = 4'hF;
    clear_counts();
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;

    // clean press on start
    clear_counts();
    base = edge_no;
    bus0.KEY = 4'b1011;
    wait_edge(5);
    chk("press e5 start", int'(bus0.btn_start), 0);
    chk("press e5 state", int'(bus0.key_state[2]), 0);
    wait_edge(6);
    chk("press e6 start", int'(bus0.btn_start), 1);
    chk("press e6 state", int'(bus0.key_state[2]), 1);
    wait_edge(7);
    chk("press e7 start", int'(bus0.btn_start), 0);
    chk("press e7 state", int'(bus0.key_state[2]), 1);
    wait_edge(20);
    bus0.KEY = 4'hF;
    wait_edge(25);
    chk("release e25 state", int'(bus0.key_state[2]), 1);
    wait_edge(26);
    chk("release e26 state", int'(bus0.key_state[2]), 0);
    chk("press start count", n_start, 1);
    chk("press other pulses", n_inc + n_dec + n_stop, 0);

    // segment table
    foreach (segs[s]) begin
      clear_counts();
      bus0.KEY = segs[s].key;
      repeat (segs[s].cycles) @(negedge clk);
      #1;
      chk($sformatf("seg%0d inc", s),   n_inc,   segs[s].n_inc);
      chk($sformatf("seg%0d dec", s),   n_dec,   segs[s].n_dec);
      chk($sformatf("seg%0d start", s), n_start, segs[s].n_start);
      chk($sformatf("seg%0d stop", s),  n_stop,  segs[s].n_stop);
      chk($sformatf("seg%0d state", s), int'(bus0.key_state), int'(segs[s].state));
    end

    // auto-repeat on decrease
    clear_counts();
    base = edge_no;
    bus0.KEY = 4'b1101;
    wait_edge(25);
    bus0.KEY = 4'hF;
    wait_edge(40);
    chk("repeat count", dec_edges.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("repeat edge%0d", i),
          (i < dec_edges.size()) ? dec_edges[i] - base : -1, exp_rep[i]);
    chk("repeat off count", dec1_edges.size(), 1);
    chk("repeat off edge", (dec1_edges.size() > 0) ? dec1_edges[0] - base : -1, 6);
    chk("repeat released state", int'(bus0.key_state), 0);

    // reset while held, including a pulse in flight
    clear_counts();
    base = edge_no;
    bus0.KEY = 4'b0111;
    wait_edge(6);
    chk("inflight stop", int'(bus0.btn_stop), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("async reset");
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("held reset");
    clear_counts();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("held state", int'(bus0.key_state), 4'b1000);
    chk("held stop count", n_stop, 0);
    bus0.KEY = 4'hF;
    repeat (12) @(negedge clk);
    #1;
    chk("held release state", int'(bus0.key_state), 0);
    chk("held release stop", n_stop, 0);
    bus0.KEY = 4'b0111;
    repeat (12) @(negedge clk);
    #1;
    chk("repress stop count", n_stop, 1);
    chk("repress state", int'(bus0.key_state), 4'b1000);
    bus0.KEY = 4'hF;
    repeat (12) @(negedge clk);
    #1;
    chk("final state", int'(bus0.key_state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
